dmem_port_arbiter: RTL and testbench

- Shares one single-port, synchronous-read data RAM (1024 x 32, byte-writable) between two requesters: instruction fetch (IF, read-only) and the MEM stage (load/store).
- Each requester uses a valid/ready request and a one-cycle response pulse.
- The block performs arbitration, word addressing and SW/SH/SB byte-strobe and write-data lane generation.
- It sits between the pipeline stages and the RAM macro.

---
 rtl/dmem_port_arbiter_if.sv | 52 +++++
 rtl/dmem_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter_if
//   Bundles the two requester handshakes (IF fetch, MEM load/store) and the
//   RAM macro port that dmem_port_arbiter sits between.
//   modport slave  : the arbiter side (takes requests, drives the RAM).
//   modport master : the pipeline/RAM side (issues requests, returns RAM data).
//   Signal names keep their _i/_o suffixes as seen from the arbiter.
// ---------------------------------------------------------------------------
interface dmem_port_arbiter_if #(
    parameter int MEM_AW = 10,
    parameter int DATA_W = 32
);
    // IF requester (read-only)
    logic                  if_req_valid_i;
    logic                  if_req_ready_o;
    logic [31:0]           if_addr_i;
    logic                  if_rsp_valid_o;
    logic [DATA_W-1:0]     if_rdata_o;
    // MEM requester (load/store)
    logic                  mem_req_valid_i;
    logic                  mem_req_ready_o;
    logic [31:0]           mem_addr_i;
    logic                  mem_wr_i;
    logic [1:0]            mem_store_type_i;
    logic [DATA_W-1:0]     mem_wdata_i;
    logic                  mem_rsp_valid_o;
    logic [DATA_W-1:0]     mem_rdata_o;
    // RAM macro port
    logic                  ram_en_o;
    logic [DATA_W/8-1:0]   ram_we_o;
    logic [MEM_AW-1:0]     ram_addr_o;
    logic [DATA_W-1:0]     ram_wdata_o;
    logic [DATA_W-1:0]     ram_rdata_i;

    modport slave (
        input  if_req_valid_i, if_addr_i,
        input  mem_req_valid_i, mem_addr_i, mem_wr_i, mem_store_type_i, mem_wdata_i,
        input  ram_rdata_i,
        output if_req_ready_o, if_rsp_valid_o, if_rdata_o,
        output mem_req_ready_o, mem_rsp_valid_o, mem_rdata_o,
        output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
    );

    modport master (
        output if_req_valid_i, if_addr_i,
        output mem_req_valid_i, mem_addr_i, mem_wr_i, mem_store_type_i, mem_wdata_i,
        output ram_rdata_i,
        input  if_req_ready_o, if_rsp_valid_o, if_rdata_o,
        input  mem_req_ready_o, mem_rsp_valid_o, mem_rdata_o,
        input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares one single-port, synchronous-read, byte-writable data RAM between
//   instruction fetch (read-only) and the MEM stage (load/store).
//   Flow per access: accept (IDLE/RESP) -> ACCESS (RAM enabled) -> RESP
//   (one-cycle response pulse to the owner). A new request may be accepted
//   in the RESP cycle, giving one access every two cycles.
//
// Ports:
//   clk     : clock, rising edge
//   resetn  : asynchronous active-low reset; drops any in-flight access
//   bus     : dmem_port_arbiter_if.slave -- IF/MEM handshakes and RAM port
//
// Optional feature:
//   DMEM_ARB_ROUND_ROBIN_EN : when defined, a tie goes to the requester not
//   granted last (last grant resets to IF). Otherwise MEM always wins a tie.
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int MEM_AW = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    dmem_port_arbiter_if.slave  bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Registered RAM command; drives the RAM port directly so it is only
    // non-zero during the ACCESS cycle.
    typedef struct packed {
        logic              en;
        logic [STRB_W-1:0] we;
        logic [MEM_AW-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } ram_cmd_t;

    state_e            state_d, state_q;
    ram_cmd_t          cmd_d, cmd_q;
    logic              owner_mem_d, owner_mem_q;
    logic              wr_d, wr_q;
    logic              if_rsp_d, if_rsp_q;
    logic              mem_rsp_d, mem_rsp_q;

    logic              can_accept;
    logic              tie_to_mem;
    logic              grant_if, grant_mem, accept;
    logic [STRB_W-1:0] st_strb;
    logic [DATA_W-1:0] st_wdata;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic              last_mem_d, last_mem_q;
`endif

    // ---------------------------------------------------------------------
    // Arbitration. Ready is gated by resetn so every output is 0 while the
    // block is held in reset, even with valids asserted.
    // ---------------------------------------------------------------------
    always_comb begin
        can_accept = resetn && (state_q != ACCESS);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        tie_to_mem = !last_mem_q;
`else
        tie_to_mem = 1'b1;
`endif
        grant_mem  = can_accept && bus.mem_req_valid_i &&
                     (!bus.if_req_valid_i || tie_to_mem);
        grant_if   = can_accept && bus.if_req_valid_i && !grant_mem;
        accept     = grant_if || grant_mem;
    end

    assign bus.if_req_ready_o  = grant_if;
    assign bus.mem_req_ready_o = grant_mem;

    // ---------------------------------------------------------------------
    // Store lane generation: strobes select the byte lanes from the low
    // address bits, write data is replicated across all lanes so the RAM
    // sees the right byte whatever lane is enabled. Type 11 behaves as SB.
    // ---------------------------------------------------------------------
    always_comb begin
        st_strb  = '0;
        st_wdata = '0;
        case (bus.mem_store_type_i)
            2'b00: begin
                st_strb  = 4'b1111;
                st_wdata = bus.mem_wdata_i;
            end
            2'b01: begin
                st_strb  = bus.mem_addr_i[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{bus.mem_wdata_i[15:0]}};
            end
            default: begin
                st_strb  = 4'b0001 << bus.mem_addr_i[1:0];
                st_wdata = {4{bus.mem_wdata_i[7:0]}};
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cmd_d       = '0;
        owner_mem_d = owner_mem_q;
        wr_d        = wr_q;
        if_rsp_d    = 1'b0;
        mem_rsp_d   = 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        last_mem_d  = last_mem_q;
`endif

        case (state_q)
            IDLE:    if (accept) state_d = ACCESS;
            ACCESS: begin
                // RAM read data lands next cycle, so the response pulse is
                // registered here and lines up with ram_rdata_i in RESP.
                state_d   = RESP;
                if_rsp_d  = !owner_mem_q;
                mem_rsp_d = owner_mem_q;
            end
            RESP:    state_d = accept ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase

        // owner/wr are still read during RESP; they only update at the end
        // of a cycle that accepts, so an overlapping accept is safe.
        if (accept) begin
            owner_mem_d = grant_mem;
            wr_d        = grant_mem && bus.mem_wr_i;
            cmd_d.en    = 1'b1;
            cmd_d.addr  = grant_mem ? bus.mem_addr_i[MEM_AW+1:2]
                                    : bus.if_addr_i[MEM_AW+1:2];
            cmd_d.we    = wr_d ? st_strb  : '0;
            cmd_d.wdata = wr_d ? st_wdata : '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_mem_d  = grant_mem;
`endif
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            owner_mem_q <= 1'b0;
            wr_q        <= 1'b0;
            if_rsp_q    <= 1'b0;
            mem_rsp_q   <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_mem_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            owner_mem_q <= owner_mem_d;
            wr_q        <= wr_d;
            if_rsp_q    <= if_rsp_d;
            mem_rsp_q   <= mem_rsp_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_mem_q  <= last_mem_d;
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.ram_en_o    = cmd_q.en;
    assign bus.ram_we_o    = cmd_q.we;
    assign bus.ram_addr_o  = cmd_q.addr;
    assign bus.ram_wdata_o = cmd_q.wdata;

    assign bus.if_rsp_valid_o  = if_rsp_q;
    assign bus.mem_rsp_valid_o = mem_rsp_q;
    // Store acknowledges return zero data; the non-owner always sees zero.
    assign bus.if_rdata_o  = if_rsp_q              ? bus.ram_rdata_i : '0;
    assign bus.mem_rdata_o = (mem_rsp_q && !wr_q)  ? bus.ram_rdata_i : '0;

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr_i[31:MEM_AW+2], bus.if_addr_i[1:0],
                                bus.mem_addr_i[31:MEM_AW+2]};

    // ---------------------------------------------------------------------
    // Invariants
    // ---------------------------------------------------------------------
    a_ready_onehot: assert property (@(posedge clk) disable iff (!resetn)
        !(bus.if_req_ready_o && bus.mem_req_ready_o));
    a_rsp_onehot: assert property (@(posedge clk) disable iff (!resetn)
        !(bus.if_rsp_valid_o && bus.mem_rsp_valid_o));
    a_we_needs_en: assert property (@(posedge clk) disable iff (!resetn)
        (bus.ram_we_o != '0) |-> bus.ram_en_o);
endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.MEM_AW(AW), .DATA_W(32)) bus();
    dmem_port_arbiter #(.MEM_AW(AW), .DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM macro model and the independent reference image of its contents
    logic [31:0] ram     [1024];
    logic [31:0] ref_mem [1024];

    always @(posedge clk) begin
        if (bus.ram_en_o) begin
            bus.ram_rdata_i <= ram[bus.ram_addr_o];
            for (int k = 0; k < 4; k++)
                if (bus.ram_we_o[k]) ram[bus.ram_addr_o][8*k +: 8] <= bus.ram_wdata_o[8*k +: 8];
        end
    end

    typedef struct { int due; logic [9:0] addr; logic [3:0] we; logic [31:0] wdata; } acc_exp_t;
    typedef struct { int due; bit is_mem; logic [31:0] data; } rsp_exp_t;
    acc_exp_t acc_q[$];
    rsp_exp_t rsp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: got none/extra, expected exact event (cycle %0d)", name, cyc);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
        acc_exp_t e;
        rsp_exp_t r;
        if (resetn) begin
            while (acc_q.size() > 0 && acc_q[0].due < cyc) begin
                fail("ram access missing");
                void'(acc_q.pop_front());
            end
            while (rsp_q.size() > 0 && rsp_q[0].due < cyc) begin
                fail("response missing");
                void'(rsp_q.pop_front());
            end
            if (bus.ram_en_o) begin
                if (acc_q.size() == 0 || acc_q[0].due != cyc) fail("ram_en unexpected");
                else begin
                    e = acc_q.pop_front();
                    chk("ram_addr", bus.ram_addr_o, e.addr);
                    chk("ram_we", bus.ram_we_o, e.we);
                    if (e.we != 4'b0) chk("ram_wdata", bus.ram_wdata_o, e.wdata);
                end
            end else begin
                chk("ram_we idle", bus.ram_we_o, 0);
                chk("ram_addr idle", bus.ram_addr_o, 0);
                chk("ram_wdata idle", bus.ram_wdata_o, 0);
            end
            if (bus.if_rsp_valid_o || bus.mem_rsp_valid_o) begin
                if (rsp_q.size() == 0 || rsp_q[0].due != cyc) fail("rsp_valid unexpected");
                else begin
                    r = rsp_q.pop_front();
                    chk("mem_rsp_valid", bus.mem_rsp_valid_o, r.is_mem);
                    chk("if_rsp_valid", bus.if_rsp_valid_o, !r.is_mem);
                    chk("rsp rdata", r.is_mem ? bus.mem_rdata_o : bus.if_rdata_o, r.data);
                    chk("non-owner rdata", r.is_mem ? bus.if_rdata_o : bus.mem_rdata_o, 0);
                end
            end
        end
    end

    // ---------------- driver + reference model ----------------
    bit          if_pend, mem_pend, mem_w, lg_mem;
    logic [31:0] if_a, mem_a, mem_wd;
    logic [1:0]  mem_t;
    int          last_acc = -100;
    int          dut_grants[$];
    int          dut_acc[$];

    task automatic drive();
        bus.if_req_valid_i   = if_pend;
        bus.if_addr_i        = if_pend ? if_a : $urandom();
        bus.mem_req_valid_i  = mem_pend;
        bus.mem_addr_i       = mem_pend ? mem_a : $urandom();
        bus.mem_wr_i         = mem_pend ? mem_w : 1'($urandom_range(0, 1));
        bus.mem_store_type_i = mem_pend ? mem_t : 2'($urandom_range(0, 3));
        bus.mem_wdata_i      = mem_pend ? mem_wd : $urandom();
    endtask

    // Accepted request -> expected RAM command and response, in order.
    task automatic model_accept(input bit is_mem);
        logic [9:0]  word;
        logic [3:0]  we;
        logic [31:0] wd;
        int size, off;
        if (!is_mem) begin
            word = if_a[11:2];
            acc_q.push_back('{cyc + 1, word, 4'b0, 32'b0});
            rsp_q.push_back('{cyc + 2, 1'b0, ref_mem[word]});
            if_pend = 0;
        end else begin
            word = mem_a[11:2];
            if (!mem_w) begin
                acc_q.push_back('{cyc + 1, word, 4'b0, 32'b0});
                rsp_q.push_back('{cyc + 2, 1'b1, ref_mem[word]});
            end else begin
                size = (mem_t == 2'd0) ? 4 : (mem_t == 2'd1) ? 2 : 1;
                off  = (size == 4) ? 0 : (size == 2) ? 2 * int'(mem_a[1]) : int'(mem_a[1:0]);
                we = '0;
                wd = '0;
                for (int b = 0; b < size; b++) begin
                    we[off + b] = 1'b1;
                    ref_mem[word][8*(off + b) +: 8] = mem_wd[8*b +: 8];
                end
                for (int k = 0; k < 4; k++) wd[8*k +: 8] = mem_wd[8*(k % size) +: 8];
                acc_q.push_back('{cyc + 1, word, we, wd});
                rsp_q.push_back('{cyc + 2, 1'b1, 32'b0});
            end
            mem_pend = 0;
        end
    endtask

    // One clock: drive at +1 after posedge, judge handshake at negedge.
    task automatic step();
        bit can, tie_mem, g_mem, g_if;
        drive();
        @(negedge clk);
        can = (cyc != last_acc + 1);   // busy only in the cycle after an acceptance
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        tie_mem = !lg_mem;
`else
        tie_mem = 1'b1;
`endif
        g_mem = can && mem_pend && (!if_pend || tie_mem);
        g_if  = can && if_pend && !g_mem;
        chk("if_req_ready", bus.if_req_ready_o, g_if);
        chk("mem_req_ready", bus.mem_req_ready_o, g_mem);
        if (bus.mem_req_ready_o && bus.mem_req_valid_i) begin
            dut_grants.push_back(1); dut_acc.push_back(cyc);
        end else if (bus.if_req_ready_o && bus.if_req_valid_i) begin
            dut_grants.push_back(0); dut_acc.push_back(cyc);
        end
        if (g_mem || g_if) begin
            last_acc = cyc;
            lg_mem   = g_mem;
            model_accept(g_mem);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input string name);
        for (int n = 0; n < 40 && (if_pend || mem_pend); n++) step();
        if (if_pend || mem_pend) fail(name);
    endtask

    task automatic arm_mem(input logic [31:0] a, input bit w, input logic [1:0] t, input logic [31:0] d);
        mem_pend = 1; mem_a = a; mem_w = w; mem_t = t; mem_wd = d;
    endtask

    initial begin
        int exp_g[4];
        logic [31:0] old;

        for (int i = 0; i < 1024; i++) begin
            ram[i]     = (i * 32'h9E37_79B1) ^ 32'h1234_5678;
            ref_mem[i] = ram[i];
        end
        ram[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
        ram[1] = 32'h1111_0001; ref_mem[1] = 32'h1111_0001;
        ram[2] = 32'h2222_0002; ref_mem[2] = 32'h2222_0002;

        // ---- reset state, valids asserted ----
        if_pend = 1; mem_pend = 1; if_a = 32'h10; arm_mem(32'h20, 1, 0, 32'hFFFF_FFFF);
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk("reset if_req_ready", bus.if_req_ready_o, 0);
        chk("reset mem_req_ready", bus.mem_req_ready_o, 0);
        chk("reset ram_en", bus.ram_en_o, 0);
        chk("reset ram_we", bus.ram_we_o, 0);
        chk("reset if_rsp_valid", bus.if_rsp_valid_o, 0);
        chk("reset mem_rsp_valid", bus.mem_rsp_valid_o, 0);
        if_pend = 0; mem_pend = 0;
        resetn = 1;

        // ---- tie: both valid for 4 accesses (first tie after reset) ----
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        exp_g = '{1, 0, 1, 0};
`else
        exp_g = '{1, 1, 1, 1};
`endif
        dut_grants.delete();
        for (int n = 0; n < 30 && dut_grants.size() < 4; n++) begin
            if (!if_pend) begin if_pend = 1; if_a = 32'h10; end
            if (!mem_pend) arm_mem({$urandom()} & 32'hFFC, 0, 0, 0);
            step();
        end
        if (dut_grants.size() < 4) fail("tie grant count");
        for (int i = 0; i < 4 && i < dut_grants.size(); i++)
            chk($sformatf("tie grant %0d (1=MEM)", i), dut_grants[i], exp_g[i]);
        run_until_idle("tie drain timeout");
        step();

        // ---- IF read of word 4 ----
        if_pend = 1; if_a = 32'h0000_0010;
        run_until_idle("if read timeout");
        // ---- SH to 0x22 ----
        arm_mem(32'h0000_0022, 1, 2'b01, 32'h0000_ABCD);
        run_until_idle("sh timeout");
        // ---- SB to each byte lane ----
        for (int o = 0; o < 4; o++) begin
            arm_mem(32'h40 + o, 1, (o == 3) ? 2'b11 : 2'b10, 32'h0000_005A);
            run_until_idle("sb timeout");
        end
        step();

        // ---- back-to-back loads, words 1 and 2 ----
        dut_acc.delete();
        arm_mem(32'h4, 0, 0, 0);
        run_until_idle("b2b first timeout");
        arm_mem(32'h8, 0, 0, 0);
        run_until_idle("b2b second timeout");
        if (dut_acc.size() >= 2) chk("b2b acceptance spacing", dut_acc[1] - dut_acc[0], 2);
        else fail("b2b acceptances");
        repeat (3) step();

        // ---- reset during ACCESS of a store ----
        old = ref_mem[100];
        arm_mem(32'h190, 1, 2'b00, 32'hCAFE_F00D);
        step();
        chk("store reached ACCESS", bus.ram_en_o, 1);
        #2 resetn = 0;
        bus.if_req_valid_i = 1; bus.mem_req_valid_i = 1;
        #1;
        chk("mid reset ram_en", bus.ram_en_o, 0);
        chk("mid reset ram_we", bus.ram_we_o, 0);
        chk("mid reset ram_addr", bus.ram_addr_o, 0);
        chk("mid reset ram_wdata", bus.ram_wdata_o, 0);
        chk("mid reset rsp", {bus.if_rsp_valid_o, bus.mem_rsp_valid_o}, 0);
        chk("mid reset ready", {bus.if_req_ready_o, bus.mem_req_ready_o}, 0);
        acc_q.delete(); rsp_q.delete();
        ref_mem[100] = old; if_pend = 0; mem_pend = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("no write after reset", ram[100], old);
        resetn = 1; last_acc = -100; lg_mem = 0;
        repeat (4) step();
        if_pend = 1; if_a = 32'h10;
        step();   // IDLE after release: accepted immediately
        run_until_idle("post reset timeout");

        // ---- randomized traffic ----
        for (int n = 0; n < 1500; n++) begin
            if (!if_pend && $urandom_range(0, 99) < 50) begin if_pend = 1; if_a = $urandom(); end
            if (!mem_pend && $urandom_range(0, 99) < 50)
                arm_mem($urandom(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom());
            step();
        end
        run_until_idle("final drain timeout");
        repeat (4) step();
        if (acc_q.size() != 0 || rsp_q.size() != 0) fail("scoreboard not empty at end");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
